code_period_reader: RTL
=======================

# code_period_reader

Reads back the per-tooth period RAM filled by the encoder generator and turns one motor revolution of tooth periods into revolution statistics. It sits on the RAM read port, opposite the encoder generator's write port. Each revolution is triggered by the zero sign, and the block publishes:
- the revolution period,
- the minimum and maximum tooth period,
- the tooth count,
- a stability flag for motor-control and status registers.

## Interface
Parameters:
- RD_LAT, 1: RAM read latency in clocks (1..3); data for an address is valid RD_LAT cycles after the address is driven.
- WR_SETTLE, 2: clocks to wait after i_zero_sign before the first read, so the writer's entry-0 write has landed.

Ports (one clock; reset is asynchronous and active-low):
- i_clk_50m  in  1  system clock, 50 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_zero_sign  in  1  one-cycle zero-index pulse (start of scan).
- i_code_wraddr  in  8  writer's current write address, sampled on i_zero_sign.
- i_tooth_num  in  8  expected teeth per revolution excluding the gap entry (e.g. 179).
- i_jitter_thr  in  24  maximum allowed (max - min) tooth period for stable.
- o_code_rdaddr  out  8  RAM read address.
- i_code_rddata  in  32  RAM read data.
- o_rev_period  out  32  sum of entries 0..last, saturating at 32'hFFFF_FFFF.
- o_tooth_min  out  32  minimum of entries 1..last.
- o_tooth_max  out  32  maximum of entries 1..last.
- o_tooth_cnt  out  8  last (number of teeth read, excluding the gap entry).
- o_stable  out  1  revolution judged stable.
- o_stat_valid  out  1  one-cycle pulse when the outputs above update.
- o_busy  out  1  scan in progress.
- o_err_overrun  out  1  one-cycle pulse when i_zero_sign arrives while busy.

## Operation
- Reset: all outputs and internal state go to 0 and the FSM enters IDLE.
- RAM layout as written:
  - Entry 0 holds the gap period, which is the one just completed at the zero sign.
  - Entries 1..last hold the teeth of the revolution just finished.
  - last is i_code_wraddr as sampled on i_zero_sign.
- FSM states:
  - IDLE: on i_zero_sign, latch last = i_code_wraddr, clear the accumulators (sum = 0, min = 32'hFFFF_FFFF, max = 0), go to SETTLE.
  - SETTLE: count WR_SETTLE cycles, then go to READ with rdaddr = 0.
  - READ: drive rdaddr each cycle, incrementing from 0 to last. After issuing last, go to DRAIN.
  - DRAIN: wait until the final data word has been accumulated (RD_LAT cycles), then go to DONE.
  - DONE: update the outputs, pulse o_stat_valid for one cycle, return to IDLE.
- Accumulation:
  - A valid-tag shift register of depth RD_LAT travels alongside the addresses, carrying an "is entry 0" flag.
  - Every returned word is added to sum; the 33-bit result is clamped on carry.
  - Words from entries other than entry 0 also update min and max.
  - The gap word is held separately for the gap check.
- o_stable = 1 only when all of the following hold:
  - last == i_tooth_num;
  - last != 0;
  - (max - min) <= {8'd0, i_jitter_thr};
  - gap >= min + (min >> 1), compared in 33 bits.
- last == 0 (motor stopped, or two zero signs with no teeth between them):
  - The block reads entry 0 only.
  - o_tooth_min = 0, o_tooth_max = 0, o_stable = 0, o_tooth_cnt = 0.
- o_busy = 1 in SETTLE, READ, DRAIN and DONE.
- Overrun: i_zero_sign while busy pulses o_err_overrun, discards the partial scan without asserting o_stat_valid, and restarts from the latch step with the new i_code_wraddr.

## Timing
- Latency from i_zero_sign to o_stat_valid is 1 + WR_SETTLE + (last + 1) + RD_LAT + 1 cycles.
  - Defaults with last = 179: 185 cycles.
  - This is well below one tooth period (about 18 000 cycles at 15 Hz with 180 teeth), so entry 1 is never overwritten mid-scan.
- rdaddr is registered. It holds its last value outside READ and is reset to 0.
- Statistic outputs hold their values between o_stat_valid pulses and change only in the DONE cycle.
- Exactly one o_stat_valid pulse per completed scan; none on an aborted scan.

## Structure
- Shared package code_rd_pkg holds:
  - the state encoding (IDLE, SETTLE, READ, DRAIN, DONE);
  - the RAM address and data widths (8 and 32);
  - the saturation constant 32'hFFFF_FFFF.
- One natural sub-module is code_stat_accum: sum, min, max and gap registers with their clear and enable inputs. The FSM and the tag pipeline stay in the top level.

## Test plan
- Uniform revolution:
  - Stimulus: entries 1..179 = 10 000, entry 0 = 20 000, last = 179, i_tooth_num = 179, i_jitter_thr = 50.
  - Response: rev_period = 1 810 000, min = max = 10 000, cnt = 179, stable = 1, o_stat_valid 185 cycles after i_zero_sign.
- Jitter:
  - Stimulus: same RAM, but entry 57 = 10 100, i_jitter_thr = 50.
  - Response: max = 10 100, stable = 0; with i_jitter_thr = 100, stable = 1.
- Missing tooth:
  - Stimulus: last = 178, i_tooth_num = 179.
  - Response: cnt = 178, stable = 0, rev_period = sum of entries 0..178.
- Weak gap:
  - Stimulus: entry 0 = 14 999, teeth = 10 000.
  - Response: stable = 0; with entry 0 = 15 000, stable = 1.
- Overrun:
  - Stimulus: second i_zero_sign 40 cycles after the first.
  - Response: o_err_overrun pulses once, no o_stat_valid for the first scan, exactly one o_stat_valid for the second scan, and the second scan's statistics are correct.
- Saturation, stopped motor and reset:
  - Saturation: all entries 32'h0200_0000 with last = 179 -> rev_period = 32'hFFFF_FFFF.
  - Stopped motor: last = 0 -> cnt = 0, min = max = 0, stable = 0.
  - Reset: assert i_rst_n low mid-READ -> all outputs 0 and FSM in IDLE immediately.

Source files
------------

// File: rtl/code_rd_pkg.sv
// Shared encodings and widths for the tooth-period RAM reader.
// The reader FSM walks the RAM once per revolution, entry 0 first.
package code_rd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Tag travelling alongside each issued read address.
  typedef struct packed {
    logic vld;
    logic is_gap;
  } tag_t;

endpackage

// File: rtl/code_stat_accum.sv
// Revolution accumulators: saturating period sum, min/max over teeth, gap word.
// Clear has priority over enable so a restart never mixes two revolutions.
module code_stat_accum
  import code_rd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_is_gap,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_gap
);

  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_gap;
  logic [DATA_W:0]   w_sum_ext;

  assign w_sum_ext = {1'b0, r_sum} + {1'b0, i_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
      r_gap <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_min <= SAT_VAL;
      r_max <= '0;
      r_gap <= '0;
    end else if (i_en) begin
      // Carry out of the 33-bit add clamps the sum for good.
      r_sum <= w_sum_ext[DATA_W] ? SAT_VAL : w_sum_ext[DATA_W-1:0];
      if (i_is_gap) begin
        r_gap <= i_data;
      end else begin
        if (i_data < r_min) r_min <= i_data;
        if (i_data > r_max) r_max <= i_data;
      end
    end
  end

  assign o_sum = r_sum;
  assign o_min = r_min;
  assign o_max = r_max;
  assign o_gap = r_gap;

endmodule

// File: rtl/code_period_reader.sv
// Reads one revolution of tooth periods from the RAM read port after each
// zero sign and publishes period, min/max tooth, tooth count and stability.
module code_period_reader
  import code_rd_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_SETTLE = 2
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_zero_sign,
  input  logic [ADDR_W-1:0] i_code_wraddr,
  input  logic [7:0]        i_tooth_num,
  input  logic [23:0]       i_jitter_thr,
  output logic [ADDR_W-1:0] o_code_rdaddr,
  input  logic [DATA_W-1:0] i_code_rddata,
  output logic [DATA_W-1:0] o_rev_period,
  output logic [DATA_W-1:0] o_tooth_min,
  output logic [DATA_W-1:0] o_tooth_max,
  output logic [7:0]        o_tooth_cnt,
  output logic              o_stable,
  output logic              o_stat_valid,
  output logic              o_busy,
  output logic              o_err_overrun
);

  localparam logic [7:0] SETTLE_END = 8'(WR_SETTLE - 1);
  localparam logic [7:0] DRAIN_END  = 8'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [7:0]        r_cnt;
  tag_t              r_tag [RD_LAT];
  tag_t              w_issue;
  logic              w_clear;
  logic              w_done;
  logic              w_overrun;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;
  logic [DATA_W-1:0] w_gap;
  logic [DATA_W-1:0] w_spread;
  logic [DATA_W:0]   w_gap_thr;
  logic              w_last_zero;
  logic              w_stable;

  logic [DATA_W-1:0] r_rev_period;
  logic [DATA_W-1:0] r_tooth_min;
  logic [DATA_W-1:0] r_tooth_max;
  logic [7:0]        r_tooth_cnt;
  logic              r_stable;
  logic              r_stat_valid;
  logic              r_err_overrun;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    w_overrun   = 1'b0;
    w_issue     = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_zero_sign) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_END) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_issue.vld    = 1'b1;
        w_issue.is_gap = (r_rdaddr == '0);
        if (r_rdaddr == r_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_END) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A new zero sign mid-scan abandons the current revolution.
    if (i_zero_sign && (r_state != ST_IDLE)) begin
      w_overrun   = 1'b1;
      w_clear     = 1'b1;
      w_done      = 1'b0;
      w_issue     = '0;
      w_state_nxt = ST_SETTLE;
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last   <= '0;
      r_rdaddr <= '0;
      r_cnt    <= '0;
    end else if (w_clear) begin
      r_last <= i_code_wraddr;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (w_state_nxt == ST_READ) begin
            r_cnt    <= '0;
            r_rdaddr <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_READ:  if (w_state_nxt == ST_READ) r_rdaddr <= r_rdaddr + 8'd1;
        ST_DRAIN: r_cnt <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Tags line up with read data RD_LAT cycles after the address.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) r_tag[i] <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < int'(RD_LAT); i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < int'(RD_LAT); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  code_stat_accum u_accum (
    .i_clk    (i_clk_50m),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .i_en     (r_tag[RD_LAT-1].vld),
    .i_is_gap (r_tag[RD_LAT-1].is_gap),
    .i_data   (i_code_rddata),
    .o_sum    (w_sum),
    .o_min    (w_min),
    .o_max    (w_max),
    .o_gap    (w_gap)
  );

  assign w_last_zero = (r_last == '0);
  assign w_spread    = w_max - w_min;
  assign w_gap_thr   = {1'b0, w_min} + {2'b00, w_min[DATA_W-1:1]};
  assign w_stable    = (r_last == i_tooth_num) && !w_last_zero &&
                       (w_spread <= {8'd0, i_jitter_thr}) &&
                       ({1'b0, w_gap} >= w_gap_thr);

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rev_period  <= '0;
      r_tooth_min   <= '0;
      r_tooth_max   <= '0;
      r_tooth_cnt   <= '0;
      r_stable      <= 1'b0;
      r_stat_valid  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_stat_valid  <= w_done;
      r_err_overrun <= w_overrun;
      if (w_done) begin
        r_rev_period <= w_sum;
        r_tooth_min  <= w_last_zero ? '0 : w_min;
        r_tooth_max  <= w_last_zero ? '0 : w_max;
        r_tooth_cnt  <= r_last;
        r_stable     <= w_stable;
      end
    end
  end

  assign o_code_rdaddr = r_rdaddr;
  assign o_rev_period  = r_rev_period;
  assign o_tooth_min   = r_tooth_min;
  assign o_tooth_max   = r_tooth_max;
  assign o_tooth_cnt   = r_tooth_cnt;
  assign o_stable      = r_stable;
  assign o_stat_valid  = r_stat_valid;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_err_overrun = r_err_overrun;

endmodule
